// File: rtl/calc_core.sv
// calc_core: keypad calculator arithmetic engine.
// Builds two decimal operands from key events and applies +, - or x on '='.
// Multiplication is a W-cycle shift-add. Output is sign-magnitude for the display.
module calc_core #(
    parameter int MAX_DIGITS = 4,
    parameter int W          = 14
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           key_valid,
    input  logic           is_number,
    input  logic           is_op,
    input  logic           is_eq,
    input  logic [3:0]     num_val,
    input  logic [1:0]     op_val,
    output logic [2*W-1:0] disp_val,
    output logic           disp_neg,
    output logic           busy,
    output logic           done
);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int CW = $clog2(W);

    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [2*W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic [2*W-1:0]  disp_q, disp_d;
    logic            neg_q, neg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Key decode: exactly one class flag, in-range values only.
    logic one_flag, dig_ev, op_ev, eq_ev;
    assign one_flag = (is_number ^ is_op ^ is_eq) & ~(is_number & is_op & is_eq);
    assign dig_ev   = key_valid & one_flag & is_number & (num_val <= 4'd9);
    assign op_ev    = key_valid & one_flag & is_op & (op_val != 2'd3);
    assign eq_ev    = key_valid & one_flag & is_eq;

    logic [W-1:0] d_ext;
    logic [DW-1:0] d_cnt;
    assign d_ext = W'(num_val);
    assign d_cnt = DW'(num_val != 4'd0);

    // Digit append for whichever operand is being typed; leading zeros not counted.
    logic [W-1:0]  x_sel, x_app;
    logic [DW-1:0] x_cnt;
    assign x_sel = (state_q == ENTER_B) ? b_q : a_q;

    // Append the incoming digit to the active operand if there is room.
    always_comb begin
        x_app = x_sel;
        x_cnt = dcnt_q;
        if (dcnt_q < DW'(MAX_DIGITS)) begin
            x_app = x_sel * W'(10) + d_ext;
            if (!(x_sel == '0 && num_val == 4'd0)) x_cnt = dcnt_q + DW'(1);
        end
    end

    // Subtraction magnitude and sign.
    logic         a_ge_b;
    logic [W-1:0] diff;
    assign a_ge_b = (a_q >= b_q);
    assign diff   = a_ge_b ? (a_q - b_q) : (b_q - a_q);

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    logic [2*W-1:0] acc_step;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        dcnt_d   = dcnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        disp_d   = disp_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            ENTER_A: begin
                if (dig_ev) begin
                    a_d    = x_app;
                    dcnt_d = x_cnt;
                    disp_d = {{W{1'b0}}, x_app};
                    neg_d  = 1'b0;
                end else if (op_ev) begin
                    op_d    = op_val;
                    dcnt_d  = '0;
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (dig_ev) begin
                    b_d     = d_ext;
                    dcnt_d  = d_cnt;
                    disp_d  = {{W{1'b0}}, d_ext};
                    neg_d   = 1'b0;
                    state_d = ENTER_B;
                end else if (op_ev) begin
                    op_d = op_val;
                end
            end
            ENTER_B: begin
                if (dig_ev) begin
                    b_d    = x_app;
                    dcnt_d = x_cnt;
                    disp_d = {{W{1'b0}}, x_app};
                end else if (eq_ev) begin
                    if (op_q == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, a_q};
                        mplier_d = b_q;
                        iter_d   = '0;
                        busy_d   = 1'b1;
                        state_d  = CALC;
                    end else begin
                        if (op_q == OP_SUB) begin
                            disp_d = {{W{1'b0}}, diff};
                            neg_d  = ~a_ge_b;
                        end else begin
                            disp_d = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                            neg_d  = 1'b0;
                        end
                        done_d  = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + CW'(1);
                if (iter_q == CW'(W - 1)) begin
                    disp_d  = acc_step;
                    neg_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (dig_ev) begin
                    a_d     = d_ext;
                    b_d     = '0;
                    dcnt_d  = d_cnt;
                    disp_d  = {{W{1'b0}}, d_ext};
                    neg_d   = 1'b0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            dcnt_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            disp_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            dcnt_q   <= dcnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            iter_q   <= iter_d;
            disp_q   <= disp_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign disp_val = disp_q;
    assign disp_neg = neg_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: doc/calc_core.md
# calc_core

Arithmetic engine of the keypad calculator. Consumes the decoded key events from the keypad interface (one-cycle `key_valid` strobe plus class flags and values). It assembles two decimal operands digit by digit, then applies +, − or × when `=` arrives. It presents the value to be shown (operand being typed, or result) as sign-magnitude binary to the downstream binary-to-BCD/display stage.

## Interface
- `MAX_DIGITS`, 4: maximum decimal digits per operand.
- `W`, 14: operand width in bits. Must satisfy 2^W > 10^MAX_DIGITS − 1.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high; clock clk.
- `key_valid`  in  1: one-cycle strobe. Class flags and values are valid in the same cycle.
- `is_number`  in  1: key is a digit.
- `is_op`  in  1: key is an operator.
- `is_eq`  in  1: key is `=`.
- `num_val`  in  4: digit 0–9.
- `op_val`  in  2: 0 = add, 1 = sub, 2 = mul, 3 = reserved (ignored).
- `disp_val`  out  2W: magnitude to display.
- `disp_neg`  out  1: displayed value is negative.
- `busy`  out  1: multiplication in progress.
- `done`  out  1: one-cycle pulse when a result is loaded into `disp_val`.

## Operation
- Inputs are sampled only when `key_valid`=1. Flags and values are ignored otherwise.
- Multiple class flags set at once → ignored. `num_val` > 9 → ignored.
- Internal registers:
  - A, B: W bits.
  - op: 2 bits.
  - dcnt: digit counter.
  - Multiplier: accumulator (2W bits), shifted multiplicand (2W bits), multiplier shift register (W bits), iteration counter.
- Digit append: X ← X·10 + d.
  - Only if dcnt < MAX_DIGITS; extra digits are ignored.
  - A digit 0 while X = 0 leaves dcnt unchanged (no leading zeros counted).
  - dcnt increments on any other accepted digit.
- States: ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT.
- ENTER_A (reset state):
  - digit → append to A; `disp_val`←A, `disp_neg`←0.
  - op (0–2) → latch op, dcnt←0, go to OP_WAIT; display unchanged.
  - `=` → ignored.
- OP_WAIT:
  - digit → B←d, dcnt←(d≠0), `disp_val`←d, go to ENTER_B.
  - op → replaces latched op.
  - `=` → ignored.
- ENTER_B:
  - digit → append to B; `disp_val`←B.
  - op → ignored (no chaining).
  - `=` with add → `disp_val`←A+B, `disp_neg`←0.
  - `=` with sub → if A ≥ B: A−B, neg 0; else B−A, neg 1.
  - Add/sub: `done`←1, go to RESULT.
  - `=` with mul → load multiplier, `busy`←1, go to CALC.
- CALC:
  - Shift-add, one multiplier bit per cycle, LSB first, exactly W iterations.
  - After the last iteration: `disp_val`←product, `disp_neg`←0, `busy`←0, `done`←1, go to RESULT.
  - All key events are ignored while in CALC (not queued).
- RESULT:
  - digit → A←d, B←0, dcnt←(d≠0), `disp_val`←d, `disp_neg`←0, go to ENTER_A.
  - op and `=` → ignored.
- Width rules:
  - All results are exact in 2W bits (max 9999·9999 = 99 980 001 < 2^28).
  - Add max 19 998; subtraction magnitude < 10^MAX_DIGITS. No overflow case exists.

## Timing
- Reset values:
  - `disp_val`=0, `disp_neg`=0, `busy`=0, `done`=0.
  - A=B=0, op=0, dcnt=0, state ENTER_A.
  - Multiplier registers cleared.
- Reset mid-CALC aborts immediately; all outputs return to reset values the cycle after.
- Digit/op events: registered on the sampling edge, visible the next cycle (latency 1).
- Add/sub: `=` sampled at edge N → result and `done`=1 in cycle N+1. `done` low again at N+2.
- Mul: `=` sampled at edge N → `busy`=1 for cycles N+1 … N+W. Result and `done`=1 in cycle N+W+1, with `busy`=0 in that same cycle.
- `done` never asserts outside the transition into RESULT. It is never high for two consecutive cycles.
- `key_valid` arriving in the same cycle the multiplication completes is ignored.
- Back-to-back `key_valid` on consecutive cycles must be handled.

## Test plan
- Reset, then keys 1,2,+,3,4,= → `disp_val`=46, `disp_neg`=0, `done` pulse one cycle after `=`; `busy` never high.
- Keys 5,−,1,2,= → `disp_val`=7, `disp_neg`=1. Keys 9,−,9,= → 0, neg 0.
- Keys 9,9,9,9,×,9,9,9,9,= → `busy` high exactly 14 cycles, then `disp_val`=99 980 001, `done` one cycle. Keys sent during `busy` change nothing.
- Keys 1,2,3,4,5 → `disp_val`=1234 (5th digit dropped). Keys 0,0,7 → 7, with dcnt allowing 3 more digits.
- Keys 3,+,−,4,= → 3−4: `disp_val`=1, neg 1. op_val=3 at any point ignored. Then digit 6 → `disp_val`=6, state ENTER_A.
- Reset asserted mid-multiply → next cycle `busy`=0, `disp_val`=0. Following 2,+,2,= yields 4.
